// File: rtl/ir_byte_demux.sv
// ir_byte_demux: steers bus bytes alternately into the high and low halves
// of an instruction register and offers the finished instruction to the
// controller through a valid/ready handshake.
module ir_byte_demux #(
   parameter int WIDTH   = 8,
   parameter int OP_BITS = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic                       byte_sel,
   output logic [2*WIDTH-1:0]         instr,
   output logic [OP_BITS-1:0]         opcode,
   output logic [2*WIDTH-OP_BITS-1:0] ir_addr,
   output logic                       instr_valid,
   input  logic                       instr_ready
);

   localparam int IW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_HI   = 2'd0,
      S_LO   = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            din_ready_s;
   logic            byte_sel_s;
   logic            accept_s;

   // State, instruction and valid registers; reset drops any partial byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HI;
         instr_q <= {IW{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign accept_s = din_valid & din_ready_s;

   // Next-state and datapath update; flush overrides every other input.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush) begin
         state_d = S_HI;
         instr_d = {IW{1'b0}};
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_HI: begin
               if (accept_s) begin
                  instr_d[IW-1 -: WIDTH] = din;
                  state_d                = S_LO;
               end else begin
                  state_d = S_HI;
               end
            end
            S_LO: begin
               if (accept_s) begin
                  instr_d[WIDTH-1:0] = din;
                  valid_d            = 1'b1;
                  state_d            = S_FULL;
               end else begin
                  state_d = S_LO;
               end
            end
            S_FULL: begin
               if (instr_ready) begin
                  valid_d = 1'b0;
                  if (accept_s) begin
                     // Next instruction's high byte lands in the release cycle.
                     instr_d[IW-1 -: WIDTH] = din;
                     state_d                = S_LO;
                  end else begin
                     state_d = S_HI;
                  end
               end else begin
                  state_d = S_FULL;
               end
            end
            default: begin
               state_d = S_HI;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Handshake outputs decoded from state; din_ready never looks at din_valid.
   always_comb begin
      din_ready_s = 1'b1;
      byte_sel_s  = 1'b0;
      case (state_q)
         S_HI: begin
            din_ready_s = 1'b1;
            byte_sel_s  = 1'b0;
         end
         S_LO: begin
            din_ready_s = 1'b1;
            byte_sel_s  = 1'b1;
         end
         S_FULL: begin
            din_ready_s = instr_ready;
            byte_sel_s  = 1'b0;
         end
         default: begin
            din_ready_s = 1'b0;
            byte_sel_s  = 1'b0;
         end
      endcase
   end

   assign din_ready   = din_ready_s;
   assign byte_sel    = byte_sel_s;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign opcode      = instr_q[IW-1 -: OP_BITS];
   assign ir_addr     = instr_q[IW-OP_BITS-1:0];

endmodule

// File: tb/tb_ir_byte_demux.sv
// Directed bench for ir_byte_demux: default 8-bit instance plus a 4-bit one.
module tb_ir_byte_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // 8-bit instance signals
   logic        flush = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic        byte_sel;
   logic [15:0] instr;
   logic [2:0]  opcode;
   logic [12:0] ir_addr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   // 4-bit instance signals
   logic        flush4 = 1'b0;
   logic [3:0]  din4 = 4'h0;
   logic        din_valid4 = 1'b0;
   logic        din_ready4;
   logic        byte_sel4;
   logic [7:0]  instr4;
   logic [1:0]  opcode4;
   logic [5:0]  ir_addr4;
   logic        instr_valid4;
   logic        instr_ready4 = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ir_byte_demux #(.WIDTH(8), .OP_BITS(3)) u8 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .byte_sel(byte_sel), .instr(instr), .opcode(opcode),
      .ir_addr(ir_addr), .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   ir_byte_demux #(.WIDTH(4), .OP_BITS(2)) u4 (
      .clk(clk), .rst_n(rst_n), .flush(flush4), .din(din4), .din_valid(din_valid4),
      .din_ready(din_ready4), .byte_sel(byte_sel4), .instr(instr4), .opcode(opcode4),
      .ir_addr(ir_addr4), .instr_valid(instr_valid4), .instr_ready(instr_ready4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; sample 2 time units later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present one byte for exactly one edge on the 8-bit instance.
   task automatic send(input logic [7:0] b);
      din = b;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      #1;
   endtask

   task automatic send4(input logic [3:0] b);
      din4 = b;
      din_valid4 = 1'b1;
      @(posedge clk);
      #1;
      din_valid4 = 1'b0;
      #1;
   endtask

   initial begin
      // ---- 1. reset, including asynchronous reset mid-instruction
      #12;
      chk("rst_instr", instr, 16'h0000);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_sel", byte_sel, 1'b0);
      chk("rst_ready", din_ready, 1'b1);
      rst_n = 1'b1;
      tick();
      send(8'hA5);
      chk("t1_hi_sel", byte_sel, 1'b1);
      chk("t1_hi_instr", instr, 16'hA500);
      #1 rst_n = 1'b0;
      #1;
      chk("t1_async_instr", instr, 16'h0000);
      chk("t1_async_valid", instr_valid, 1'b0);
      chk("t1_async_sel", byte_sel, 1'b0);
      chk("t1_async_ready", din_ready, 1'b1);
      tick();
      chk("t1_hold_instr", instr, 16'h0000);
      #1 rst_n = 1'b1;
      send(8'h12);
      chk("t1_valid_mid", instr_valid, 1'b0);
      send(8'h34);
      chk("t1_instr", instr, 16'h1234);
      chk("t1_valid", instr_valid, 1'b1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t1_release", instr_valid, 1'b0);

      // ---- 2. basic assembly and hold under back-pressure
      send(8'hE3);
      chk("t2_valid_after_hi", instr_valid, 1'b0);
      send(8'h7F);
      chk("t2_valid", instr_valid, 1'b1);
      chk("t2_instr", instr, 16'hE37F);
      chk("t2_opcode", opcode, 3'b111);
      chk("t2_addr", ir_addr, 13'h037F);
      din = 8'h55;
      din_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_hold_ready", din_ready, 1'b0);
         chk("t2_hold_sel", byte_sel, 1'b0);
         tick();
         chk("t2_hold_instr", instr, 16'hE37F);
         chk("t2_hold_valid", instr_valid, 1'b1);
      end
      din_valid = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("t2_ready_pass", din_ready, 1'b1);
      tick();
      chk("t2_release", instr_valid, 1'b0);

      // ---- 3. back-to-back with consumer always ready
      send(8'h11);
      chk("t3_v0", instr_valid, 1'b0);
      send(8'h22);
      chk("t3_v1", instr_valid, 1'b1);
      chk("t3_i1", instr, 16'h1122);
      chk("t3_full_ready", din_ready, 1'b1);
      send(8'h33);
      chk("t3_v2", instr_valid, 1'b0);
      chk("t3_sel2", byte_sel, 1'b1);
      send(8'h44);
      chk("t3_v3", instr_valid, 1'b1);
      chk("t3_i3", instr, 16'h3344);
      tick();
      chk("t3_v4", instr_valid, 1'b0);
      chk("t3_sel4", byte_sel, 1'b0);
      instr_ready = 1'b0;

      // ---- 4. input stall between high and low byte
      send(8'h5A);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_gap_sel", byte_sel, 1'b1);
         chk("t4_gap_valid", instr_valid, 1'b0);
      end
      send(8'hC3);
      chk("t4_instr", instr, 16'h5AC3);
      chk("t4_valid", instr_valid, 1'b1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;

      // ---- 5. flush during low byte, then flush of a held instruction
      send(8'h01);
      flush = 1'b1;
      send(8'h99);
      flush = 1'b0;
      chk("t5_valid", instr_valid, 1'b0);
      chk("t5_instr", instr, 16'h0000);
      chk("t5_sel", byte_sel, 1'b0);
      send(8'hBE);
      send(8'hEF);
      chk("t5_full", instr, 16'hBEEF);
      chk("t5_full_valid", instr_valid, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush_valid", instr_valid, 1'b0);
      chk("t5_flush_instr", instr, 16'h0000);
      chk("t5_flush_ready", din_ready, 1'b1);

      // ---- 6. narrow instance
      send4(4'hD);
      chk("t6_sel", byte_sel4, 1'b1);
      send4(4'h6);
      chk("t6_instr", instr4, 8'hD6);
      chk("t6_opcode", opcode4, 2'b11);
      chk("t6_addr", ir_addr4, 6'h16);
      chk("t6_valid", instr_valid4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ir_byte_demux.md
Name: ir_byte_demux

Overview:
- Sequential 1-to-2 byte demultiplexer and instruction assembler; the inverse of the address/data mux path.
- Takes WIDTH-bit bytes off the shared data bus and steers them alternately into the high half and low half of a 2*WIDTH instruction register.
- Presents the assembled instruction, split into opcode and operand address, to the controller with a valid/ready handshake.
- Sits between the ROM/RAM data bus and the CPU control state machine.

Parameters:
- WIDTH, 8, bus byte width; instruction width is 2*WIDTH.
- OP_BITS, 3, opcode width taken from the MSBs of the instruction; must satisfy 1 <= OP_BITS < 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the partial or held instruction.
- din  input  WIDTH  byte from the data bus.
- din_valid  input  1  din carries a byte this cycle.
- din_ready  output  1  block accepts din this cycle.
- byte_sel  output  1  destination of the next accepted byte: 0 = high half, 1 = low half.
- instr  output  2*WIDTH  assembled instruction, {high byte, low byte}.
- opcode  output  OP_BITS  instr[2*WIDTH-1 -: OP_BITS].
- ir_addr  output  2*WIDTH-OP_BITS  remaining low bits of instr.
- instr_valid  output  1  instr holds a complete instruction.
- instr_ready  input  1  consumer takes instr this cycle.

Behaviour:
- States:
  - S_HI: waiting for the high byte.
  - S_LO: waiting for the low byte.
  - S_FULL: complete instruction held.
- Reset (rst_n low, asynchronous):
  - state = S_HI; instr = 0; instr_valid = 0; byte_sel = 0.
  - All outputs hold these values until the first clock edge after rst_n deasserts.
  - Reset mid-instruction discards any partial byte.
- A byte is accepted only when din_valid and din_ready are both high in the same cycle.
- S_HI:
  - din_ready = 1; byte_sel = 0.
  - On accept: instr[2W-1:W] <= din; go to S_LO.
  - instr[W-1:0] keeps its old value.
- S_LO:
  - din_ready = 1; byte_sel = 1.
  - On accept: instr[W-1:0] <= din; instr_valid <= 1; go to S_FULL.
- S_FULL:
  - instr_valid = 1; byte_sel = 0; din_ready = instr_ready (combinational pass-through).
  - instr_ready = 0: instr held stable; no byte accepted.
  - instr_ready = 1 and no accept: instr_valid <= 0; go to S_HI.
  - instr_ready = 1 and accept in the same cycle: high byte of the next instruction is written; instr_valid <= 0; go to S_LO.
- Back-to-back throughput is one instruction per 2 accepted bytes, with no bubble.
- Latency: instr_valid rises on the clock edge that accepts the low byte.
- opcode and ir_addr are combinational slices of the instr register.
- din_valid low: state holds in every state; there is no timeout.
- flush:
  - Sampled on the clock edge and has priority over all other inputs.
  - Next state = S_HI; instr_valid <= 0; instr <= 0.
  - A byte presented in the same cycle is dropped, even if din_valid and din_ready are both high.
- Handshake rules:
  - din_ready must not depend on din_valid.
  - instr_valid, once high, stays high with instr unchanged until instr_ready or flush.
- instr_ready while instr_valid = 0 is ignored.

Test Plan:
1. Reset with rst_n = 0 mid-S_LO (after high byte 8'hA5) -> immediately instr = 16'h0000, instr_valid = 0, byte_sel = 0, din_ready = 1; next bytes 8'h12, 8'h34 -> instr = 16'h1234.
2. Basic assembly: din 8'hE3 then 8'h7F, one per cycle, instr_ready = 0 -> instr_valid = 1 on the second edge; instr = 16'hE37F, opcode = 3'b111, ir_addr = 13'h037F. Holding 5 cycles with din_valid = 1 -> din_ready = 0 and instr unchanged.
3. Back-to-back: continuous bytes 8'h11, 8'h22, 8'h33, 8'h44 with instr_ready = 1 -> instr_valid high for exactly one cycle with 16'h1122, then one cycle with 16'h3344; no byte dropped.
4. Stall on input: high byte 8'h5A, din_valid = 0 for 4 cycles, then 8'hC3 -> byte_sel = 1 throughout the gap; instr = 16'h5AC3.
5. Flush: flush asserted in the cycle the low byte 8'h99 is presented after high byte 8'h01 -> instr_valid stays 0, instr = 0, state S_HI. Flush while S_FULL holds 16'hBEEF -> instr_valid = 0 next cycle.
6. Parameter sweep: WIDTH = 4, OP_BITS = 2; bytes 4'hD, 4'h6 -> instr = 8'hD6, opcode = 2'b11, ir_addr = 6'h16.
